// File: rtl/shift_reg_pkg.sv
// -----------------------------------------------------------------------------
// shift_reg_pkg
// Shared definitions for the universal shift register:
//   - mode_e     : 3-bit operation select encoding
//   - is_shift() : true for the shift class (SHR, SHL, ROR, ROL)
//   - is_reload(): true for operations that restart a frame (LOAD, CLR)
// -----------------------------------------------------------------------------
package shift_reg_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_SHR  = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_ROR  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_LOAD = 3'b101,
        MODE_CLR  = 3'b110,
        MODE_RSVD = 3'b111   // reserved, behaves as HOLD
    } mode_e;

    // Every operation that moves a bit through the register counts toward a frame,
    // regardless of direction or whether the exiting bit is recirculated.
    function automatic logic is_shift(input logic [2:0] mode);
        return (mode == MODE_SHR) || (mode == MODE_SHL) ||
               (mode == MODE_ROR) || (mode == MODE_ROL);
    endfunction

    // LOAD and CLR overwrite the whole register, so any partial frame is abandoned.
    function automatic logic is_reload(input logic [2:0] mode);
        return (mode == MODE_LOAD) || (mode == MODE_CLR);
    endfunction

endpackage : shift_reg_pkg

// File: rtl/shift_frame_counter.sv
// -----------------------------------------------------------------------------
// shift_frame_counter
// Counts shift-class operations modulo WIDTH and emits a registered one-cycle
// pulse on the edge that completes the WIDTH-th shift of a frame.
// Ports:
//   clk    in   clock, rising edge
//   resetn in   synchronous active-low reset
//   inc    in   one shift-class operation this cycle
//   clr    in   restart the frame (priority over inc), no done pulse
//   count  out  shifts completed in the current frame, 0..WIDTH-1
//   done   out  frame-complete pulse
// -----------------------------------------------------------------------------
module shift_frame_counter #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic             done_q, done_d;

    always_comb begin
        count_d = count_q;
        done_d  = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            if (count_q == LAST) begin
                // Wrap straight to 0 so back-to-back frames have no bubble.
                count_d = '0;
                done_d  = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign count = count_q;
    assign done  = done_q;

endmodule : shift_frame_counter

// File: rtl/shift_reg_univ.sv
// -----------------------------------------------------------------------------
// shift_reg_univ
// Parametrised universal shift register: bidirectional shift, rotate, parallel
// load, synchronous clear, clock enable and a shift-frame counter.
// Ports:
//   clk    in   clock, rising edge
//   resetn in   synchronous active-low reset, overrides everything
//   en     in   clock enable; 0 holds all state
//   mode   in   operation select (see shift_reg_pkg::mode_e)
//   sinp   in   serial input bit
//   pin    in   parallel load data
//   pout   out  register contents
//   sout   out  bit that exited on the last shift/rotate (0 after LOAD/CLR)
//   count  out  shifts completed in the current frame
//   done   out  one-cycle pulse after the WIDTH-th shift of a frame
// All outputs are registered; there is no input-to-output combinational path.
// -----------------------------------------------------------------------------
module shift_reg_univ
    import shift_reg_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sinp,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] pout,
    output logic             sout,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    logic [WIDTH-1:0] pout_q, pout_d;
    logic             sout_q, sout_d;
    logic             cnt_inc, cnt_clr;

    always_comb begin
        pout_d = pout_q;
        sout_d = sout_q;
        if (en) begin
            case (mode)
                MODE_SHR: begin
                    pout_d = {sinp, pout_q[WIDTH-1:1]};
                    sout_d = pout_q[0];
                end
                MODE_SHL: begin
                    pout_d = {pout_q[WIDTH-2:0], sinp};
                    sout_d = pout_q[WIDTH-1];
                end
                MODE_ROR: begin
                    pout_d = {pout_q[0], pout_q[WIDTH-1:1]};
                    sout_d = pout_q[0];
                end
                MODE_ROL: begin
                    pout_d = {pout_q[WIDTH-2:0], pout_q[WIDTH-1]};
                    sout_d = pout_q[WIDTH-1];
                end
                MODE_LOAD: begin
                    pout_d = pin;
                    sout_d = 1'b0;
                end
                MODE_CLR: begin
                    pout_d = '0;
                    sout_d = 1'b0;
                end
                default: begin
                    // HOLD and the reserved code keep the current state.
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pout_q <= '0;
            sout_q <= 1'b0;
        end else begin
            pout_q <= pout_d;
            sout_q <= sout_d;
        end
    end

    assign cnt_inc = en & is_shift(mode);
    assign cnt_clr = en & is_reload(mode);

    shift_frame_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_frame_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (cnt_inc),
        .clr    (cnt_clr),
        .count  (count),
        .done   (done)
    );

    assign pout = pout_q;
    assign sout = sout_q;

endmodule : shift_reg_univ

// File: tb/tb_shift_reg_univ.sv
// -----------------------------------------------------------------------------
// tb_shift_reg_univ
// Two instances (WIDTH=4 and WIDTH=8). Each stimulus step pushes the model's
// expected output onto a queue; after the edge the entry is popped and compared.
// -----------------------------------------------------------------------------
module tb_shift_reg_univ;

    typedef struct packed {
        logic [7:0] pout;
        logic       sout;
        logic [3:0] count;
        logic       done;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=4 instance
    logic       resetn4 = 1'b0, en4 = 1'b0, sinp4 = 1'b0;
    logic [2:0] mode4 = 3'b000;
    logic [3:0] pin4 = 4'h0;
    logic [3:0] pout4;
    logic       sout4;
    logic [2:0] count4;
    logic       done4;

    // WIDTH=8 instance
    logic       resetn8 = 1'b0, en8 = 1'b0, sinp8 = 1'b0;
    logic [2:0] mode8 = 3'b000;
    logic [7:0] pin8 = 8'h00;
    logic [7:0] pout8;
    logic       sout8;
    logic [3:0] count8;
    logic       done8;

    shift_reg_univ #(.WIDTH(4)) u_dut4 (
        .clk(clk), .resetn(resetn4), .en(en4), .mode(mode4), .sinp(sinp4),
        .pin(pin4), .pout(pout4), .sout(sout4), .count(count4), .done(done4)
    );

    shift_reg_univ #(.WIDTH(8)) u_dut8 (
        .clk(clk), .resetn(resetn8), .en(en8), .mode(mode8), .sinp(sinp8),
        .pin(pin8), .pout(pout8), .sout(sout8), .count(count8), .done(done8)
    );

    int   checks = 0;
    int   errors = 0;
    obs_t q4[$];
    obs_t q8[$];
    obs_t m4 = '0;
    obs_t m8 = '0;
    obs_t exp_o, got_o;

    // Behavioural reference for a WIDTH-w register (w <= 8).
    function automatic obs_t model(input obs_t s, input int w, input logic rn,
                                   input logic en, input logic [2:0] md,
                                   input logic si, input logic [7:0] pi);
        obs_t       n;
        logic [7:0] mask;
        logic [7:0] sbit;
        logic [7:0] top;
        n      = s;
        n.done = 1'b0;
        mask   = 8'hFF >> (8 - w);
        sbit   = {7'b0, si} << (w - 1);
        top    = {7'b0, s.pout[0]} << (w - 1);
        if (!rn) return '0;
        if (!en) return n;
        case (md)
            3'd1: begin n.pout = ((s.pout >> 1) | sbit) & mask;           n.sout = s.pout[0];   end
            3'd2: begin n.pout = ((s.pout << 1) | {7'b0, si}) & mask;     n.sout = s.pout[w-1]; end
            3'd3: begin n.pout = ((s.pout >> 1) | top) & mask;            n.sout = s.pout[0];   end
            3'd4: begin n.pout = ((s.pout << 1) | {7'b0, s.pout[w-1]}) & mask; n.sout = s.pout[w-1]; end
            3'd5: begin n.pout = pi & mask; n.sout = 1'b0; n.count = 4'd0; end
            3'd6: begin n.pout = 8'h00;     n.sout = 1'b0; n.count = 4'd0; end
            default: ;
        endcase
        if (md >= 3'd1 && md <= 3'd4) begin
            if (int'(s.count) == w - 1) begin
                n.count = 4'd0;
                n.done  = 1'b1;
            end else begin
                n.count = s.count + 4'd1;
            end
        end
        return n;
    endfunction

    task automatic step4(input logic rn, input logic en, input logic [2:0] md,
                         input logic si, input logic [3:0] pi);
        resetn4 = rn; en4 = en; mode4 = md; sinp4 = si; pin4 = pi;
        m4 = model(m4, 4, rn, en, md, si, {4'b0, pi});
        q4.push_back(m4);
        @(posedge clk);
        #1;
    endtask

    task automatic step8(input logic rn, input logic en, input logic [2:0] md,
                         input logic si, input logic [7:0] pi);
        resetn8 = rn; en8 = en; mode8 = md; sinp8 = si; pin8 = pi;
        m8 = model(m8, 8, rn, en, md, si, pi);
        q8.push_back(m8);
        @(posedge clk);
        #1;
    endtask

    function automatic obs_t obs4();
        return {4'b0, pout4, sout4, 1'b0, count4, done4};
    endfunction

    function automatic obs_t obs8();
        return {pout8, sout8, count8, done8};
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step4(1'b0, 1'b1, 3'b101, 1'b1, 4'hF);
            exp_o = q4.pop_front(); got_o = obs4(); checks++;
            if (got_o !== exp_o || got_o !== obs_t'(0)) begin
                errors++;
                $display("FAIL reset[%0d] got pout=%h sout=%b count=%0d done=%b, expected all zero",
                         i, got_o.pout, got_o.sout, got_o.count, got_o.done);
            end
            $display("reset[%0d] pout=%h sout=%b count=%0d done=%b", i, pout4, sout4, count4, done4);
        end
    endtask

    task automatic test_shr();
        logic [3:0] sin_t  = 4'b1101;   // applied LSB first: 1,0,1,1
        logic [3:0] pout_t [4] = '{4'b1000, 4'b0100, 4'b1010, 4'b1101};
        for (int i = 0; i < 4; i++) begin
            step4(1'b1, 1'b1, 3'b001, sin_t[i], 4'h0);
            exp_o = q4.pop_front(); got_o = obs4(); checks++;
            if (got_o !== exp_o || pout4 !== pout_t[i] || sout4 !== 1'b0 || done4 !== (i == 3)) begin
                errors++;
                $display("FAIL shr[%0d] got pout=%h sout=%b count=%0d done=%b, expected pout=%h sout=%b count=%0d done=%b",
                         i, got_o.pout, got_o.sout, got_o.count, got_o.done,
                         exp_o.pout, exp_o.sout, exp_o.count, exp_o.done);
            end
            $display("shr[%0d] pout=%b sout=%b count=%0d done=%b", i, pout4, sout4, count4, done4);
        end
    endtask

    task automatic test_shl();
        logic [3:0] pout_t [4] = '{4'b0110, 4'b1100, 4'b1000, 4'b0000};
        logic [3:0] sout_t = 4'b1101;   // 1,0,1,1 indexed by i
        step4(1'b1, 1'b1, 3'b101, 1'b0, 4'b1011);
        exp_o = q4.pop_front(); got_o = obs4(); checks++;
        if (got_o !== exp_o || pout4 !== 4'b1011 || count4 !== 3'd0) begin
            errors++;
            $display("FAIL shl_load got pout=%h count=%0d, expected pout=%h count=%0d",
                     got_o.pout, got_o.count, exp_o.pout, exp_o.count);
        end
        for (int i = 0; i < 4; i++) begin
            step4(1'b1, 1'b1, 3'b010, 1'b0, 4'h0);
            exp_o = q4.pop_front(); got_o = obs4(); checks++;
            if (got_o !== exp_o || pout4 !== pout_t[i] || sout4 !== sout_t[i] || done4 !== (i == 3)) begin
                errors++;
                $display("FAIL shl[%0d] got pout=%h sout=%b count=%0d done=%b, expected pout=%h sout=%b count=%0d done=%b",
                         i, got_o.pout, got_o.sout, got_o.count, got_o.done,
                         exp_o.pout, exp_o.sout, exp_o.count, exp_o.done);
            end
            $display("shl[%0d] pout=%b sout=%b count=%0d done=%b", i, pout4, sout4, count4, done4);
        end
    endtask

    task automatic test_rotate();
        logic [3:0] pout_t [4] = '{4'b0011, 4'b0110, 4'b1100, 4'b1001};
        step4(1'b1, 1'b1, 3'b101, 1'b0, 4'b1001);
        void'(q4.pop_front());
        for (int i = 0; i < 4; i++) begin
            step4(1'b1, 1'b1, 3'b100, 1'b0, 4'h0);
            exp_o = q4.pop_front(); got_o = obs4(); checks++;
            if (got_o !== exp_o || pout4 !== pout_t[i] || done4 !== (i == 3)) begin
                errors++;
                $display("FAIL rol[%0d] got pout=%h sout=%b count=%0d done=%b, expected pout=%h sout=%b count=%0d done=%b",
                         i, got_o.pout, got_o.sout, got_o.count, got_o.done,
                         exp_o.pout, exp_o.sout, exp_o.count, exp_o.done);
            end
            $display("rol[%0d] pout=%b count=%0d done=%b", i, pout4, count4, done4);
        end
        step4(1'b1, 1'b1, 3'b011, 1'b0, 4'h0);
        exp_o = q4.pop_front(); got_o = obs4(); checks++;
        if (got_o !== exp_o || pout4 !== 4'b1100 || count4 !== 3'd1 || sout4 !== 1'b1) begin
            errors++;
            $display("FAIL ror got pout=%h sout=%b count=%0d, expected pout=%h sout=%b count=%0d",
                     got_o.pout, got_o.sout, got_o.count, exp_o.pout, exp_o.sout, exp_o.count);
        end
        $display("ror pout=%b sout=%b count=%0d", pout4, sout4, count4);
    endtask

    task automatic test_abandon();
        // Sequence: LOAD 0, SHR x2, en=0 x3, CLR, SHR x2, reset
        logic       en_t [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [2:0] md_t [9] = '{3'd5, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd6, 3'd1, 3'd1};
        logic [2:0] cnt_t[9] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd0, 3'd1, 3'd2};
        for (int i = 0; i < 9; i++) begin
            step4(1'b1, en_t[i], md_t[i], 1'b1, 4'h0);
            exp_o = q4.pop_front(); got_o = obs4(); checks++;
            if (got_o !== exp_o || count4 !== cnt_t[i] || done4 !== 1'b0) begin
                errors++;
                $display("FAIL abandon[%0d] got pout=%h sout=%b count=%0d done=%b, expected pout=%h sout=%b count=%0d done=%b",
                         i, got_o.pout, got_o.sout, got_o.count, got_o.done,
                         exp_o.pout, exp_o.sout, exp_o.count, exp_o.done);
            end
            $display("abandon[%0d] en=%b mode=%0d pout=%b count=%0d done=%b", i, en_t[i], md_t[i], pout4, count4, done4);
        end
        step4(1'b0, 1'b1, 3'd1, 1'b1, 4'hF);
        exp_o = q4.pop_front(); got_o = obs4(); checks++;
        if (got_o !== exp_o || got_o !== obs_t'(0)) begin
            errors++;
            $display("FAIL abandon_reset got pout=%h sout=%b count=%0d done=%b, expected all zero",
                     got_o.pout, got_o.sout, got_o.count, got_o.done);
        end
        $display("abandon_reset pout=%b count=%0d", pout4, count4);
    endtask

    task automatic test_reserved();
        step4(1'b1, 1'b1, 3'd5, 1'b0, 4'b0110);
        void'(q4.pop_front());
        for (int i = 0; i < 3; i++) begin
            step4(1'b1, 1'b1, 3'd7, 1'b1, 4'hF);
            exp_o = q4.pop_front(); got_o = obs4(); checks++;
            if (got_o !== exp_o || pout4 !== 4'b0110 || count4 !== 3'd0 || done4 !== 1'b0) begin
                errors++;
                $display("FAIL reserved[%0d] got pout=%h count=%0d done=%b, expected pout=%h count=%0d done=%b",
                         i, got_o.pout, got_o.count, got_o.done, exp_o.pout, exp_o.count, exp_o.done);
            end
            $display("reserved[%0d] pout=%b count=%0d done=%b", i, pout4, count4, done4);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            step4(1'b1, 1'b1, 3'd1 + 3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 4'h0);
            exp_o = q4.pop_front(); got_o = obs4(); checks++;
            // After reserved test count is 0, so every 4th shift completes a frame.
            if (got_o !== exp_o || done4 !== ((i % 4) == 3)) begin
                errors++;
                $display("FAIL b2b[%0d] got pout=%h sout=%b count=%0d done=%b, expected pout=%h sout=%b count=%0d done=%b",
                         i, got_o.pout, got_o.sout, got_o.count, got_o.done,
                         exp_o.pout, exp_o.sout, exp_o.count, exp_o.done);
            end
            $display("b2b[%0d] pout=%b sout=%b count=%0d done=%b", i, pout4, sout4, count4, done4);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            step4(1'($urandom_range(0, 15) != 0), 1'($urandom_range(0, 3) != 0),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            exp_o = q4.pop_front(); got_o = obs4(); checks++;
            if (got_o !== exp_o) begin
                errors++;
                $display("FAIL rand[%0d] got pout=%h sout=%b count=%0d done=%b, expected pout=%h sout=%b count=%0d done=%b",
                         i, got_o.pout, got_o.sout, got_o.count, got_o.done,
                         exp_o.pout, exp_o.sout, exp_o.count, exp_o.done);
            end
            $display("rand[%0d] rn=%b en=%b mode=%0d pout=%b sout=%b count=%0d done=%b",
                     i, resetn4, en4, mode4, pout4, sout4, count4, done4);
        end
    endtask

    task automatic test_width8();
        logic [7:0] sin_t = 8'b0100_1011;
        step8(1'b0, 1'b1, 3'd5, 1'b0, 8'hFF);
        exp_o = q8.pop_front(); got_o = obs8(); checks++;
        if (got_o !== exp_o || got_o !== obs_t'(0)) begin
            errors++;
            $display("FAIL w8_reset got pout=%h sout=%b count=%0d done=%b, expected all zero",
                     got_o.pout, got_o.sout, got_o.count, got_o.done);
        end
        for (int i = 0; i < 10; i++) begin
            step8(1'b1, 1'b1, 3'd1, sin_t[i % 8], 8'h00);
            exp_o = q8.pop_front(); got_o = obs8(); checks++;
            if (got_o !== exp_o || done8 !== (i == 7)) begin
                errors++;
                $display("FAIL w8_shr[%0d] got pout=%h sout=%b count=%0d done=%b, expected pout=%h sout=%b count=%0d done=%b",
                         i, got_o.pout, got_o.sout, got_o.count, got_o.done,
                         exp_o.pout, exp_o.sout, exp_o.count, exp_o.done);
            end
            $display("w8_shr[%0d] pout=%b sout=%b count=%0d done=%b", i, pout8, sout8, count8, done8);
        end
        checks++;
        if (pout8 !== 8'b1101_0010) begin
            errors++;
            $display("FAIL w8_final got pout=%b, expected pout=11010010", pout8);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_shr();
        test_shl();
        test_rotate();
        test_abandon();
        test_reserved();
        test_back_to_back();
        test_random();
        test_width8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_shift_reg_univ

// File: doc/shift_reg_univ.md
# shift_reg_univ

Parametrised universal shift register, the next generation of the 4-bit serial-in/parallel-out register. Adds configurable width, bidirectional shift, rotate, parallel load, synchronous clear, clock enable and a shift-frame counter with a one-cycle `done` pulse every WIDTH shifts. Used as a serialiser/deserialiser stage between serial links and WIDTH-bit datapaths.

## Interface
- `WIDTH`, default 4. Register width; legal range is WIDTH ≥ 2.
- `CNT_W`, derived localparam = $clog2(WIDTH+1). Counter width; not overridable.
- `clk`  in  1  Sole clock; all state updates on the rising edge.
- `resetn`  in  1  Reset, synchronous, active-low; priority over all other inputs.
- `en`  in  1  Clock enable. When 0, all state holds.
- `mode`  in  3  Operation select; encoding listed under Operation.
- `sinp`  in  1  Serial input bit.
- `pin`  in  WIDTH  Parallel load data.
- `pout`  out  WIDTH  Register contents (registered).
- `sout`  out  1  Bit that exited on the last shift or rotate (registered).
- `count`  out  CNT_W  Shifts completed in the current frame, range 0..WIDTH-1.
- `done`  out  1  One-cycle pulse on the edge that completes the WIDTH-th shift of a frame.

## Operation
- Mode encoding:
  - 000 HOLD.
  - 001 SHR: `pout <= {sinp, pout[W-1:1]}`, `sout <= pout[0]`.
  - 010 SHL: `pout <= {pout[W-2:0], sinp}`, `sout <= pout[W-1]`.
  - 011 ROR: `pout <= {pout[0], pout[W-1:1]}`, `sout <= pout[0]`.
  - 100 ROL: `pout <= {pout[W-2:0], pout[W-1]}`, `sout <= pout[W-1]`.
  - 101 LOAD: `pout <= pin`.
  - 110 CLR: `pout <= 0`.
  - 111 reserved; behaves exactly as HOLD.
- Shift class is SHR, SHL, ROR and ROL. Each shift-class operation with `en`=1 increments `count`.
- When `count` = WIDTH-1 and a shift-class operation occurs:
  - `count` wraps to 0.
  - `done` = 1 for that cycle only.
- LOAD and CLR:
  - `count` <= 0 and `sout` <= 0.
  - `done` = 0.
  - A frame in progress is abandoned with no `done`.
- HOLD, reserved mode, or `en`=0: `pout`, `sout` and `count` hold; `done` = 0.
- Direction may change mid-frame. `count` still increments, so a frame is any WIDTH shift-class operations.
- Reset (`resetn`=0 at an edge): `pout`=0, `sout`=0, `count`=0, `done`=0.
  - Reset overrides `en` and `mode`.
  - Reset mid-frame discards the partial frame.

## Timing
- All outputs are registered. Each output reflects the inputs sampled at the previous rising edge (latency 1).
- `done` is a registered pulse. It is high during the cycle after the completing edge and low on the following edge unless another frame completes.
- With WIDTH=1-cycle frames impossible (WIDTH ≥ 2), two `done` pulses are at least WIDTH cycles apart.
- Back-to-back frames: continuous shifting gives `done` every WIDTH cycles with no bubble.
- No combinational path from any input to any output.

## Structure
- Package `shift_reg_pkg`:
  - Mode encoding constants `MODE_HOLD` … `MODE_CLR`.
  - Function `is_shift(mode)`.
- Sub-module `shift_frame_counter` (params WIDTH, CNT_W; ports `clk`, `resetn`, `inc`, `clr`; outputs `count`, `done`).
  - `clr` has priority over `inc`.
- Top level contains the data register, the mode mux and the `sout` register.

## Test plan
- Reset: hold `resetn`=0 for 2 cycles with `mode`=101 and `pin`=1111 -> `pout`=0000, `sout`=0, `count`=0, `done`=0.
- SHR from 0000 with `sinp`=1,0,1,1 -> `pout`=1000, 0100, 1010, 1101; `sout`=0 each cycle; `count`=1, 2, 3, 0; `done` high only after the 4th shift.
- LOAD 1011, then SHL with `sinp`=0 ×4 -> `pout`=0110, 1100, 1000, 0000; `sout`=1, 0, 1, 1; one `done` pulse.
- LOAD 1001, then ROL ×4 -> `pout`=0011, 0110, 1100, 1001; `done` on 4th; then ROR ×1 -> `pout`=1100, `count`=1.
- Abandon: 2 shifts, then `en`=0 for 3 cycles (state held, `count`=2), then CLR -> `count`=0, no `done`; then 2 shifts and assert `resetn`=0 -> all outputs 0 at the next edge.
- Mode 111 for 3 cycles after LOAD 0110 -> `pout`=0110, `count`=0, `done`=0 throughout; repeat with WIDTH=8, SHR ×8 -> `done` after the 8th shift only.
